// File: rtl/gmii_rx_video_pkg.sv
// Shared definitions for the GMII video receiver: FSM states, header byte
// offsets and the packet-type values also used by the transmitter.
package gmii_rx_video_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_HDR,
    ST_PTYPE,
    ST_LINE,
    ST_PIX,
    ST_TAIL,
    ST_DROP
  } rx_state_t;

  localparam logic [7:0] PREAMBLE = 8'h55;
  localparam logic [7:0] SFD      = 8'hD5;

  // Byte offsets counted from the first destination MAC byte
  localparam logic [5:0] OFF_DST_MAC   = 6'd0;
  localparam logic [5:0] OFF_ETYPE     = 6'd12;
  localparam logic [5:0] OFF_VER_IHL   = 6'd14;
  localparam logic [5:0] OFF_PROTO     = 6'd23;
  localparam logic [5:0] OFF_UDP_DPORT = 6'd36;
  localparam logic [5:0] HDR_LAST      = 6'd41;

  localparam logic [15:0] ETH_IPV4     = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL   = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP = 8'h11;
  localparam logic [7:0]  PT_VIDEO     = 8'h00;
  localparam logic [7:0]  PT_AUDIO     = 8'h01;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

  // True when a header byte at offset idx is acceptable; unchecked offsets always pass
  function automatic logic hdr_byte_ok(input logic [5:0]  idx,
                                       input logic [7:0]  b,
                                       input logic [47:0] mac,
                                       input logic [15:0] port);
    logic ok;
    ok = 1'b1;
    case (idx)
      OFF_DST_MAC:          ok = (b == mac[47:40]);
      OFF_DST_MAC + 6'd1:   ok = (b == mac[39:32]);
      OFF_DST_MAC + 6'd2:   ok = (b == mac[31:24]);
      OFF_DST_MAC + 6'd3:   ok = (b == mac[23:16]);
      OFF_DST_MAC + 6'd4:   ok = (b == mac[15:8]);
      OFF_DST_MAC + 6'd5:   ok = (b == mac[7:0]);
      OFF_ETYPE:            ok = (b == ETH_IPV4[15:8]);
      OFF_ETYPE + 6'd1:     ok = (b == ETH_IPV4[7:0]);
      OFF_VER_IHL:          ok = (b == IP_VER_IHL);
      OFF_PROTO:            ok = (b == IP_PROTO_UDP);
      OFF_UDP_DPORT:        ok = (b == port[15:8]);
      OFF_UDP_DPORT + 6'd1: ok = (b == port[7:0]);
      default:              ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Counter increment that sticks at all-ones
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // The reflected CRC register is compared against the residue in normal bit order
  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/gmii_rx_video_crc32_d8.sv
// One byte step of the reflected Ethernet CRC-32 (polynomial 04C11DB7, LSB first).
module crc32_d8 (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_REFL = 32'hEDB8_8320;

  // Eight serial shift steps unrolled into one combinational update
  always_comb begin
    crc_out = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++)
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ POLY_REFL) : (crc_out >> 1);
  end

endmodule

// File: rtl/gmii_rx_video.sv
// GMII receiver for the display board: filters Ethernet/IPv4/UDP video frames
// and writes one line of Y/C pairs per packet into the pixel FIFO.
// Optional FCS checking is enabled by defining CRC_CHECK_EN.
module gmii_rx_video
  import gmii_rx_video_pkg::*;
#(
  parameter logic [47:0] MY_MAC    = 48'h00_23_45_67_89_02,
  parameter logic [15:0] UDP_PORT  = 16'd12345,
  parameter logic [10:0] PIX_BYTES = 11'd1280
) (
  input  logic        rx_clk,
  input  logic        sys_rst_n,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  input  logic        vid_full,
  output logic        vid_wr_en,
  output logic [27:0] vid_din,
  output logic        line_done,
  output logic [15:0] drop_cnt,
  output logic        ovf,
  output logic        crc_err
);

  rx_state_t   state;
  logic [10:0] byte_cnt;
  logic [3:0]  line_hi;
  logic [11:0] line_q;
  logic [7:0]  y_q;
  logic        bad_byte;
  logic        crc_bad;

  // Flag the current byte as a reason to abandon the frame
  always_comb begin
    bad_byte = 1'b0;
    case (state)
      ST_PRE:   bad_byte = (rxd != SFD) && (rxd != PREAMBLE);
      ST_HDR:   bad_byte = !hdr_byte_ok(byte_cnt[5:0], rxd, MY_MAC, UDP_PORT);
      ST_PTYPE: bad_byte = (rxd != PT_VIDEO);
      default:  bad_byte = 1'b0;
    endcase
  end

  // Frame parser FSM with registered FIFO, status and drop-count outputs
  always_ff @(posedge rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      byte_cnt  <= '0;
      line_hi   <= '0;
      line_q    <= '0;
      y_q       <= '0;
      vid_wr_en <= 1'b0;
      vid_din   <= '0;
      line_done <= 1'b0;
      drop_cnt  <= '0;
      ovf       <= 1'b0;
    end else begin
      vid_wr_en <= 1'b0;
      line_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_dv && rxd == PREAMBLE) state <= ST_PRE;
        end
        ST_DROP: begin
          if (!rx_dv) state <= ST_IDLE;
        end
        default: begin
          if (!rx_dv) begin
            state <= ST_IDLE;
            if (state != ST_TAIL || crc_bad) drop_cnt <= sat_inc(drop_cnt);
          end else if (rx_er || bad_byte) begin
            state    <= ST_DROP;
            drop_cnt <= sat_inc(drop_cnt);
          end else begin
            byte_cnt <= byte_cnt + 11'd1;
            case (state)
              ST_PRE: begin
                if (rxd == SFD) begin
                  state    <= ST_HDR;
                  byte_cnt <= '0;
                end
              end
              ST_HDR: begin
                if (byte_cnt[5:0] == HDR_LAST) state <= ST_PTYPE;
              end
              ST_PTYPE: begin
                state    <= ST_LINE;
                byte_cnt <= '0;
              end
              ST_LINE: begin
                if (!byte_cnt[0]) begin
                  line_hi <= rxd[3:0];
                end else begin
                  line_q   <= {line_hi, rxd};
                  state    <= ST_PIX;
                  byte_cnt <= '0;
                end
              end
              ST_PIX: begin
                if (!byte_cnt[0]) begin
                  y_q <= rxd;
                end else if (vid_full) begin
                  ovf <= 1'b1;
                end else begin
                  vid_wr_en <= 1'b1;
                  vid_din   <= {line_q, y_q, rxd};
                end
                if (byte_cnt == PIX_BYTES - 11'd1) begin
                  line_done <= 1'b1;
                  state     <= ST_TAIL;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

`ifdef CRC_CHECK_EN
  logic [31:0] crc_q;
  logic [31:0] crc_next;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (rxd),
    .crc_out (crc_next)
  );

  assign crc_bad = (bit_rev32(crc_q) != CRC_RESIDUE);

  // Running CRC from the first destination MAC byte through the FCS
  always_ff @(posedge rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      crc_q <= CRC_INIT;
    else if (state == ST_PRE)
      crc_q <= CRC_INIT;
    else if (rx_dv && state != ST_IDLE && state != ST_DROP)
      crc_q <= crc_next;
  end

  // Pulse once when a frame ends in TAIL with a bad residue
  always_ff @(posedge rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      crc_err <= 1'b0;
    else
      crc_err <= (state == ST_TAIL) && !rx_dv && crc_bad;
  end
`else
  assign crc_bad = 1'b0;
  assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_gmii_rx_video.sv
// Directed, table-driven bench for gmii_rx_video: builds complete GMII frames,
// streams them byte by byte and checks FIFO writes, status and counters.
`timescale 1ns/1ps
module tb_gmii_rx_video;

  localparam int PIX_BYTES = 1280;
  localparam int PIX_START = 53;

  logic        rx_clk    = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        rx_dv     = 1'b0;
  logic        rx_er     = 1'b0;
  logic [7:0]  rxd       = 8'h00;
  logic        vid_full  = 1'b0;
  logic        vid_wr_en;
  logic [27:0] vid_din;
  logic        line_done;
  logic [15:0] drop_cnt;
  logic        ovf;
  logic        crc_err;

  gmii_rx_video dut (
    .rx_clk    (rx_clk),
    .sys_rst_n (sys_rst_n),
    .rx_dv     (rx_dv),
    .rx_er     (rx_er),
    .rxd       (rxd),
    .vid_full  (vid_full),
    .vid_wr_en (vid_wr_en),
    .vid_din   (vid_din),
    .line_done (line_done),
    .drop_cnt  (drop_cnt),
    .ovf       (ovf),
    .crc_err   (crc_err)
  );

  always #4 rx_clk = ~rx_clk;

  typedef struct {
    logic [7:0]  mac_last;
    logic [7:0]  ptype;
    logic [11:0] line;
    int          full_lo;
    int          full_hi;
    int          cut_at;
    int          er_at;
    int          rst_at;
    bit          flip_fcs;
    int          gap;
    int          exp_wr;
    int          exp_ld;
    int          exp_drop_inc;
    int          exp_crc;
    bit          chk_first;
    logic [27:0] exp_first;
  } vec_t;

  vec_t vecs[11];

  int checks   = 0;
  int errors   = 0;
  int exp_drop = 0;
  bit exp_ovf  = 1'b0;

  int          wr_cnt     = 0;
  int          ld_cnt     = 0;
  int          crc_cnt    = 0;
  int          data_bad   = 0;
  int          exp_idx    = 0;
  int          mon_lo     = -1;
  int          mon_hi     = -1;
  logic [11:0] mon_line   = 12'h000;
  logic [27:0] first_din  = 28'h0;
  bit          first_seen = 1'b0;

  // Output monitor: predicts each written pair, skipping the pairs lost to vid_full
  always @(negedge rx_clk) begin : monitor
    logic [7:0] yv;
    if (vid_wr_en) begin
      while (exp_idx >= mon_lo && exp_idx <= mon_hi) exp_idx++;
      yv = exp_idx[7:0];
      if (!first_seen) begin
        first_din  = vid_din;
        first_seen = 1'b1;
      end
      if (vid_din !== {mon_line, yv, ~yv}) data_bad++;
      exp_idx++;
      wr_cnt++;
    end
    if (line_done) ld_cnt++;
    if (crc_err) crc_cnt++;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int row);
    logic [7:0]  frm[$];
    logic [7:0]  hdr[42];
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [7:0]  b8;
    int          p;
    bit          ovf_before;
    bit          stopped;

    hdr = '{8'h00, 8'h23, 8'h45, 8'h67, 8'h89, 8'h02,
            8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
            8'h08, 8'h00, 8'h45, 8'h00, 8'h05, 8'h2A,
            8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
            8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h0A,
            8'hC0, 8'hA8, 8'h01, 8'h14, 8'h04, 8'hD2,
            8'h30, 8'h39, 8'h05, 8'h16, 8'h00, 8'h00};
    hdr[5] = v.mac_last;

    frm = {};
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int i = 0; i < 42; i++) frm.push_back(hdr[i]);
    frm.push_back(v.ptype);
    frm.push_back({4'h0, v.line[11:8]});
    frm.push_back(v.line[7:0]);
    for (int i = 0; i < PIX_BYTES / 2; i++) begin
      b8 = i[7:0];
      frm.push_back(b8);
      frm.push_back(~b8);
    end
    crc = 32'hFFFFFFFF;
    for (int i = 8; i < frm.size(); i++) crc = crcByte(crc, frm[i]);
    fcs = ~crc;
    if (v.flip_fcs) fcs = fcs ^ 32'h1;
    frm.push_back(fcs[7:0]);
    frm.push_back(fcs[15:8]);
    frm.push_back(fcs[23:16]);
    frm.push_back(fcs[31:24]);

    wr_cnt     = 0;
    ld_cnt     = 0;
    crc_cnt    = 0;
    data_bad   = 0;
    exp_idx    = 0;
    first_seen = 1'b0;
    mon_line   = v.line;
    mon_lo     = v.full_lo;
    mon_hi     = v.full_hi;
    ovf_before = exp_ovf;
    stopped    = 1'b0;

    for (int i = 0; i < frm.size(); i++) begin
      p = i - PIX_START;
      @(negedge rx_clk);
      if (v.full_lo >= 0 && !ovf_before && p == 2 * v.full_lo + 1)
        checkOutput($sformatf("r%0d_ovf_before_full", row), int'(ovf), 0);
      if (v.full_lo >= 0 && !ovf_before && p == 2 * v.full_lo + 2)
        checkOutput($sformatf("r%0d_ovf_after_full", row), int'(ovf), 1);
      if (v.cut_at >= 0 && p == v.cut_at) begin
        rx_dv    = 1'b0;
        vid_full = 1'b0;
        stopped  = 1'b1;
        break;
      end
      if (v.rst_at >= 0 && p == v.rst_at) begin
        sys_rst_n = 1'b0;
        rx_dv     = 1'b0;
        vid_full  = 1'b0;
        repeat (2) @(negedge rx_clk);
        sys_rst_n = 1'b1;
        exp_drop  = 0;
        exp_ovf   = 1'b0;
        stopped   = 1'b1;
        break;
      end
      rx_dv    = 1'b1;
      rxd      = frm[i];
      rx_er    = (v.er_at >= 0 && (i - 8) == v.er_at);
      vid_full = (p >= 0 && (p % 2) == 1 && (p / 2) >= v.full_lo && (p / 2) <= v.full_hi);
    end
    if (!stopped) @(negedge rx_clk);
    rx_dv    = 1'b0;
    rx_er    = 1'b0;
    vid_full = 1'b0;
    rxd      = 8'h00;
    repeat (v.gap - 1) @(negedge rx_clk);
    #1;

    exp_drop += v.exp_drop_inc;
    if (v.full_lo >= 0) exp_ovf = 1'b1;

    checkOutput($sformatf("r%0d_writes", row), wr_cnt, v.exp_wr);
    checkOutput($sformatf("r%0d_line_done", row), ld_cnt, v.exp_ld);
    checkOutput($sformatf("r%0d_drop_cnt", row), int'(drop_cnt), exp_drop);
    checkOutput($sformatf("r%0d_ovf", row), int'(ovf), int'(exp_ovf));
    checkOutput($sformatf("r%0d_crc_err", row), crc_cnt, v.exp_crc);
    checkOutput($sformatf("r%0d_pixel_data", row), data_bad, 0);
    if (v.chk_first)
      checkOutput($sformatf("r%0d_first_din", row), int'(first_din), int'(v.exp_first));
  endtask

  initial begin
    //            mac    ptype  line     lo  hi  cut  er   rst  flip gap wr   ld dinc crc chk  first
    vecs[0]  = '{8'h02, 8'h00, 12'h02D, -1, -1, -1,  -1,  -1, 1'b0, 3, 640, 1, 0, 0, 1'b1, 28'h02D00FF};
    vecs[1]  = '{8'h03, 8'h00, 12'h02D, -1, -1, -1,  -1,  -1, 1'b0, 3, 0,   0, 1, 0, 1'b0, 28'h0};
    vecs[2]  = '{8'h02, 8'h00, 12'h123, -1, -1, -1,  -1,  -1, 1'b0, 3, 640, 1, 0, 0, 1'b1, 28'h12300FF};
    vecs[3]  = '{8'h02, 8'h01, 12'h02D, -1, -1, -1,  -1,  -1, 1'b0, 1, 0,   0, 1, 0, 1'b0, 28'h0};
    vecs[4]  = '{8'h02, 8'h00, 12'h200, 10, 19, -1,  -1,  -1, 1'b0, 3, 630, 1, 0, 0, 1'b1, 28'h20000FF};
    vecs[5]  = '{8'h02, 8'h00, 12'h055, -1, -1, 100, -1,  -1, 1'b0, 3, 50,  0, 1, 0, 1'b0, 28'h0};
    vecs[6]  = '{8'h02, 8'h00, 12'h066, -1, -1, -1,  20,  -1, 1'b0, 3, 0,   0, 1, 0, 1'b0, 28'h0};
`ifdef CRC_CHECK_EN
    vecs[7]  = '{8'h02, 8'h00, 12'h077, -1, -1, -1,  -1,  -1, 1'b1, 3, 640, 1, 1, 1, 1'b0, 28'h0};
`else
    vecs[7]  = '{8'h02, 8'h00, 12'h077, -1, -1, -1,  -1,  -1, 1'b1, 3, 640, 1, 0, 0, 1'b0, 28'h0};
`endif
    vecs[8]  = '{8'h02, 8'h00, 12'hFFF, -1, -1, -1,  -1,  -1, 1'b0, 3, 640, 1, 0, 0, 1'b1, 28'hFFF00FF};
    vecs[9]  = '{8'h02, 8'h00, 12'h0AB, -1, -1, -1,  -1,  51, 1'b0, 3, 25,  0, 0, 0, 1'b0, 28'h0};
    vecs[10] = '{8'h02, 8'h00, 12'h001, -1, -1, -1,  -1,  -1, 1'b0, 3, 640, 1, 0, 0, 1'b1, 28'h00100FF};

    sys_rst_n = 1'b0;
    repeat (3) @(negedge rx_clk);
    checkOutput("reset_vid_wr_en", int'(vid_wr_en), 0);
    checkOutput("reset_vid_din", int'(vid_din), 0);
    checkOutput("reset_line_done", int'(line_done), 0);
    checkOutput("reset_drop_cnt", int'(drop_cnt), 0);
    checkOutput("reset_ovf", int'(ovf), 0);
    checkOutput("reset_crc_err", int'(crc_err), 0);
    sys_rst_n = 1'b1;

    // rx_er while idle must not count as a dropped frame
    @(negedge rx_clk);
    rx_er = 1'b1;
    repeat (3) @(negedge rx_clk);
    rx_er = 1'b0;
    @(negedge rx_clk);
    checkOutput("idle_rx_er_ignored", int'(drop_cnt), 0);

    for (int r = 0; r < 11; r++) begin
      $display("[TB] row %0d", r);
      applyStimulus(vecs[r], r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
